// File: rtl/delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl
//
// Controller for a delay line. It does three jobs:
//   * Detects bursts on the received signal and enables the tri-state output
//     driver while the burst and its delayed tail are replayed.
//   * Loads new delay lengths through a valid/ready handshake. A load is only
//     accepted between bursts, and every load flushes the line.
//   * Enforces a dead time after every burst and every reload.
//
// Optional feature: define DELAY_LINE_CTRL_TIMEOUT_EN to add a burst timeout.
// When enabled, a burst longer than MAX_BURST cycles is forced to end and the
// sticky overrun flag is set. When undefined, overrun is tied low.
//
// Ports
//   clk        in   system clock (PLL output), the only clock
//   reset      in   synchronous, active-high reset
//   in_sig     in   raw asynchronous received signal
//   cfg_delay  in   requested delay length [DW-1:0]
//   cfg_valid  in   cfg_delay valid; held by the source until accepted
//   cfg_ready  out  controller can accept cfg_delay (IDLE only)
//   delay_len  out  delay length applied to the delay line [DW-1:0]
//   dl_flush   out  one-cycle clear of the delay line contents
//   out_en     out  output driver enable (registered)
//   busy       out  FSM is in any state other than IDLE
//   overrun    out  sticky burst-timeout flag
// ---------------------------------------------------------------------------
module delay_line_ctrl #(
    parameter int DW            = 16,
    parameter int DEFAULT_DELAY = 1000,
    parameter int MAX_DELAY     = 65535,
    parameter int HOLD_CYCLES   = 16,
    parameter int GUARD_CYCLES  = 64,
    parameter int MAX_BURST     = 1000000,
    parameter bit IDLE_LEVEL    = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_sig,
    input  logic [DW-1:0] cfg_delay,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic [DW-1:0] delay_len,
    output logic          dl_flush,
    output logic          out_en,
    output logic          busy,
    output logic          overrun
);

    localparam logic [DW-1:0] DEF_LEN    = DW'(DEFAULT_DELAY);
    localparam logic [DW-1:0] MAX_LEN    = DW'(MAX_DELAY);
    localparam logic [DW+1:0] HOLD_W     = (DW+2)'(HOLD_CYCLES);
    localparam int            GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    // Reject parameter sets that would make the counters meaningless.
    if (GUARD_CYCLES < 1) begin : g_bad_guard
        $error("delay_line_ctrl: GUARD_CYCLES must be at least 1");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("delay_line_ctrl: MAX_BURST must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GUARD  = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_delay_len;
    logic [DW-1:0] r_burst_len;   // delay_len snapshot taken at burst start
    logic [DW-1:0] r_cfg_data;    // cfg_delay captured on the handshake edge
    logic [DW:0]   r_quiet_cnt;
    logic [GW-1:0] r_guard_cnt;
    logic          r_out_en;
    logic          r_dl_flush;

    logic          w_in_active;
    logic [DW+1:0] w_quiet_lim;
    logic          w_quiet_done;
    logic [DW-1:0] w_clamped;

    // Line is considered active whenever the synchronised level leaves idle.
    assign w_in_active = (r_sync2 != IDLE_LEVEL);

    // The quiet limit is built one bit wider than quiet_cnt, so the sum of
    // the delay length and the hold time cannot wrap.
    assign w_quiet_lim  = {2'b00, r_burst_len} + HOLD_W;
    assign w_quiet_done = ({1'b0, r_quiet_cnt} == w_quiet_lim);

    // A zero-length line is not meaningful, so 0 loads 1. Oversize values
    // load MAX_DELAY.
    always_comb begin
        w_clamped = r_cfg_data;
        if (r_cfg_data == '0)
            w_clamped = DW'(1);
        else if (r_cfg_data > MAX_LEN)
            w_clamped = MAX_LEN;
    end

`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
    localparam logic [31:0] BURST_LAST = 32'(MAX_BURST - 1);
    logic [31:0] r_burst_cnt;
    logic        r_overrun;
    logic        w_timeout;

    assign w_timeout = (r_burst_cnt == BURST_LAST);
    assign overrun   = r_overrun;
`else
    assign overrun   = 1'b0;
`endif

    // Two-flop synchroniser. The flops reset to the idle level, so reset
    // cannot look like the start of a burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= in_sig;
            r_sync2 <= r_sync1;
        end
    end

    // Main FSM. out_en and dl_flush are registered, so there is no
    // combinational path from in_sig to the driver enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_delay_len <= DEF_LEN;
            r_burst_len <= DEF_LEN;
            r_cfg_data  <= '0;
            r_quiet_cnt <= '0;
            r_guard_cnt <= '0;
            r_out_en    <= 1'b0;
            r_dl_flush  <= 1'b0;
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
            r_burst_cnt <= '0;
            r_overrun   <= 1'b0;
`endif
        end else begin
            r_dl_flush <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A reload takes priority over a burst seen in the same
                    // cycle. That burst is picked up once the guard ends.
                    if (cfg_valid) begin
                        r_state    <= ST_LOAD;
                        r_cfg_data <= cfg_delay;
                        r_dl_flush <= 1'b1;
                    end else if (w_in_active) begin
                        r_state     <= ST_ACTIVE;
                        r_out_en    <= 1'b1;
                        r_quiet_cnt <= '0;
                        r_burst_len <= r_delay_len;
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
                        r_burst_cnt <= '0;
`endif
                    end
                end

                ST_ACTIVE: begin
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
                    r_burst_cnt <= r_burst_cnt + 32'd1;
                    if (w_timeout) begin
                        r_state     <= ST_GUARD;
                        r_out_en    <= 1'b0;
                        r_guard_cnt <= '0;
                        r_overrun   <= 1'b1;
                    end else
`endif
                    // Fresh activity restarts the quiet window, even on the
                    // cycle the window would otherwise have expired.
                    if (w_in_active) begin
                        r_quiet_cnt <= '0;
                    end else if (w_quiet_done) begin
                        r_state     <= ST_GUARD;
                        r_out_en    <= 1'b0;
                        r_guard_cnt <= '0;
                    end else if (r_quiet_cnt != '1) begin
                        r_quiet_cnt <= r_quiet_cnt + (DW+1)'(1);
                    end
                end

                ST_GUARD: begin
                    if (r_guard_cnt == GUARD_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + GW'(1);
                    end
                end

                ST_LOAD: begin
                    r_delay_len <= w_clamped;
                    r_state     <= ST_GUARD;
                    r_guard_cnt <= '0;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_out_en <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign delay_len = r_delay_len;
    assign dl_flush  = r_dl_flush;
    assign out_en    = r_out_en;

endmodule
